// File: rtl/sdp_fifo_pkg.sv
// Shared constants for the RAM-backed stream FIFO: RAM read latency and skid geometry.
// No logic, no latency, no backpressure of its own.
// Consumers size their read-tag pipe and skid counters from these values.
package sdp_fifo_pkg;
    localparam int READ_LATENCY = 2;
    localparam int SKID_DEPTH   = 4;
    localparam int SKID_PTR_W   = $clog2(SKID_DEPTH);
    localparam int SKID_CNT_W   = SKID_PTR_W + 1;
endpackage

// File: rtl/fifo_skid_buffer.sv
// Small circular buffer that catches RAM read data so the head word is always registered.
// Write lands on the clock edge, head is visible the next cycle; pop and write may coincide.
// No backpressure on write: the producer reserves space before issuing a read.
module fifo_skid_buffer
    import sdp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [SKID_CNT_W-1:0] count
);
    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_idx;
    logic [SKID_PTR_W-1:0] rd_idx;
    logic                  pop_eff;

    assign rd_valid = (count != '0);
    assign pop_eff  = pop & rd_valid;
    assign rd_data  = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
                wr_idx      <= wr_idx + 1'b1;
            end
            if (pop_eff) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (wr_en && !pop_eff) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop_eff) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdp_ram_fifo_ctrl.sv
// Valid/ready FIFO controller around a 2-port RAM (port A write, port B read, 2-cycle read).
// Latency: push into empty FIFO shows out_valid 4 cycles later; 1 word/cycle sustained.
// Backpressure: in_ready drops when the RAM is full; optional fill_level via SDP_FIFO_FILL_LEVEL_EN.
module sdp_ram_fifo_ctrl
    import sdp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_in_a,
    output logic                  ram_write_en_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_data_in_b,
    output logic                  ram_write_en_b,
    input  logic [DATA_WIDTH-1:0] ram_data_out_b
`ifdef SDP_FIFO_FILL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] fill_level
`endif
);
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH:0]     ram_count;
    logic [READ_LATENCY-1:0] tag;
    logic                    accept_en;
    logic [SKID_CNT_W-1:0]   inflight;
    logic [SKID_CNT_W-1:0]   skid_count;
    logic                    push;
    logic                    issue;

    // ram_count never exceeds DEPTH, so its MSB alone flags "full"
    assign in_ready = accept_en & ~ram_count[ADDR_WIDTH];
    assign push     = in_valid & in_ready;
    assign inflight = SKID_CNT_W'($countones(tag));
    // skid space is reserved for every read in flight, so captures can never overflow
    assign issue    = (ram_count != '0) &&
                      ((inflight + skid_count) < SKID_CNT_W'(SKID_DEPTH));

    assign ram_write_en_a = push;
    assign ram_addr_a     = wr_ptr;
    assign ram_data_in_a  = in_data;
    assign ram_addr_b     = rd_ptr;
    assign ram_data_in_b  = '0;
    assign ram_write_en_b = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            tag       <= '0;
            accept_en <= 1'b0;
        end else begin
            accept_en <= 1'b1;
            tag       <= {tag[READ_LATENCY-2:0], issue};
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !issue) begin
                ram_count <= ram_count + 1'b1;
            end else if (!push && issue) begin
                ram_count <= ram_count - 1'b1;
            end
        end
    end

    fifo_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tag[READ_LATENCY-1]),
        .wr_data (ram_data_out_b),
        .pop     (out_ready),
        .rd_valid(out_valid),
        .rd_data (out_data),
        .count   (skid_count)
    );

`ifdef SDP_FIFO_FILL_LEVEL_EN
    localparam int FILL_W = ADDR_WIDTH + 2;
    assign fill_level = FILL_W'(ram_count) + FILL_W'(inflight) + FILL_W'(skid_count);
`else
    // occupancy is not exported in this build
`endif
endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// Bench for sdp_ram_fifo_ctrl with a behavioural 2-cycle RAM and a queue-based reference model.
module tb_sdp_ram_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_data;
    logic [5:0]  ram_addr_a;
    logic [13:0] ram_data_in_a;
    logic        ram_write_en_a;
    logic [5:0]  ram_addr_b;
    logic [13:0] ram_data_in_b;
    logic        ram_write_en_b;
    logic [13:0] ram_data_out_b;
`ifdef SDP_FIFO_FILL_LEVEL_EN
    logic [7:0]  fill_level;
`endif

    always #5 clk = ~clk;

    sdp_ram_fifo_ctrl #(.DATA_WIDTH(14), .ADDR_WIDTH(6)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .ram_addr_a    (ram_addr_a),
        .ram_data_in_a (ram_data_in_a),
        .ram_write_en_a(ram_write_en_a),
        .ram_addr_b    (ram_addr_b),
        .ram_data_in_b (ram_data_in_b),
        .ram_write_en_b(ram_write_en_b),
        .ram_data_out_b(ram_data_out_b)
`ifdef SDP_FIFO_FILL_LEVEL_EN
        ,
        .fill_level    (fill_level)
`endif
    );

    // RAM: registered address, registered data -> data 2 cycles after the address
    logic [13:0] ram_mem [64];
    logic [5:0]  addr_b_q;
    logic [13:0] dout_q;
    always @(posedge clk) begin
        if (ram_write_en_a) ram_mem[ram_addr_a] <= ram_data_in_a;
        addr_b_q <= ram_addr_b;
        dout_q   <= ram_mem[addr_b_q];
    end
    assign ram_data_out_b = dout_q;

    logic [13:0] model_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  did_push;
    bit  did_pop;
    int  skid_max = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // one clock cycle: called at a negedge, returns at the next negedge
    task automatic step(input bit iv, input logic [13:0] id, input bit ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        did_push = in_valid && in_ready;
        did_pop  = out_valid && out_ready;
        if (did_pop) begin
            if (model_q.size() == 0) chk("pop_when_empty", 1, 0);
            else chk("pop_data", 32'(out_data), 32'(model_q.pop_front()));
        end
        if (did_push) model_q.push_back(id);
        if (int'(u_dut.u_skid.count) > skid_max) skid_max = int'(u_dut.u_skid.count);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rdy, sent, got, first_pop, last_pop, push_c, pop_c, guard;

        rst_n = 1'b0; in_valid = 1'b1; in_data = 14'h1234; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_we_a", ram_write_en_a, 0);
        end
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // single word, cycle-accurate
        in_valid = 1'b1; in_data = 14'h2ABC; out_ready = 1'b1;
        #1;
        chk("single_we_a", ram_write_en_a, 1);
        chk("single_addr_a", ram_addr_a, 0);
        chk("single_din_a", ram_data_in_a, 14'h2ABC);
        chk("single_c0_valid", out_valid, 0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk($sformatf("single_c%0d_valid", c), out_valid, (c == 4) ? 1 : 0);
            if (c == 4) chk("single_data", out_data, 14'h2ABC);
            @(posedge clk); @(negedge clk);
        end

        // fill to DEPTH+4 with the sink stalled
        for (int i = 0; i < 68; i++) begin
            guard = 0;
            do begin step(1'b1, 14'(i), 1'b0); guard++; end while (!did_push && guard < 20);
            if (!did_push) chk("full_push_timeout", i, 68);
        end
        repeat (4) step(1'b0, 14'h0, 1'b0);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_model_size", model_q.size(), 68);
        first_rdy = -1;
        for (int c = 0; c < 300 && model_q.size() > 0; c++) begin
            if (first_rdy < 0 && in_ready) first_rdy = c;
            step(1'b0, 14'h0, 1'b1);
        end
        chk("full_drained", model_q.size(), 0);
        chk("full_rdy_latency", first_rdy, 2);
        repeat (4) step(1'b0, 14'h0, 1'b1);
        chk("full_idle_valid", out_valid, 0);

        // streaming, both sides always ready
        sent = 0; got = 0; first_pop = -1; last_pop = -1;
        for (int c = 0; c < 400 && got < 200; c++) begin
            step(sent < 200, 14'(sent), 1'b1);
            if (did_push) sent++;
            if (did_pop) begin
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                got++;
            end
        end
        chk("stream_count", got, 200);
        chk("stream_first_cycle", first_pop, 4);
        chk("stream_last_cycle", last_pop, 203);

        // random backpressure on both sides
        sent = 0; got = 0;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            step((sent < 1000) && ($urandom_range(0, 1) == 1), 14'($urandom), $urandom_range(0, 1) == 1);
            if (did_push) sent++;
            if (did_pop) got++;
        end
        chk("bp_count", got, 1000);
        chk("bp_model_empty", model_q.size(), 0);
        chk("skid_never_over_4", skid_max <= 4, 1);

        // reset with words queued
        sent = 0; guard = 0;
        while (sent < 20 && guard < 100) begin
            step(1'b1, 14'($urandom), 1'b0);
            if (did_push) sent++;
            guard++;
        end
        chk("mid_queued", sent, 20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        model_q.delete();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        push_c = -1; pop_c = -1;
        for (int c = 0; c < 40 && pop_c < 0; c++) begin
            step(push_c < 0, 14'h0155, 1'b1);
            if (did_push && push_c < 0) push_c = c;
            if (did_pop) pop_c = c;
        end
        chk("mid_push_cycle", push_c, 0);
        chk("mid_first_latency", pop_c - push_c, 4);
        repeat (6) step(1'b0, 14'h0, 1'b1);
        chk("mid_no_stale", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
